// File: rtl/key_bank_loader.sv
// Key bank loader: captures NUM_KEYS key words that arrive as qualified beats, then locks
// the set. It flags interrupted loads, idle timeouts and overwrite attempts as errors.
module key_bank_loader #(
   parameter int unsigned KEY_W    = 64,
   parameter int unsigned NUM_KEYS = 3,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [KEY_W-1:0]              data_in,
   input  logic                          key_config,
   input  logic                          in_valid,
   input  logic                          clear,
   output logic                          rdy,
   output logic [NUM_KEYS*KEY_W-1:0]     key_out,
   output logic                          keys_valid,
   output logic [$clog2(NUM_KEYS+1)-1:0] key_idx,
   output logic                          done,
   output logic                          error
);

   localparam int unsigned IDX_W = $clog2(NUM_KEYS + 1);
   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);
   // The cycle that would bring the idle counter up to TIMEOUT is the one that errors out.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StLocked, StErr} state_e;

   state_e                      r_state;
   logic [NUM_KEYS*KEY_W-1:0]   r_bank;
   logic [IDX_W-1:0]            r_idx;
   logic [CNT_W-1:0]            r_idle_cnt;
   logic                        r_done;
   logic                        r_error;

   state_e                      w_state_d;
   logic [IDX_W-1:0]            w_idx_d;
   logic [CNT_W-1:0]            w_cnt_d;
   logic                        w_done_d;
   logic                        w_error_d;
   logic                        w_key_we;
   logic                        w_accept;

   assign rdy        = (r_state == StIdle) || (r_state == StLoad);
   assign keys_valid = (r_state == StLocked);
   assign key_out    = r_bank;
   assign key_idx    = r_idx;
   assign done       = r_done;
   assign error      = r_error;
   assign w_accept   = rdy && in_valid && key_config;

   // Next-state and control: clear overrides everything, including a beat in the same cycle.
   always_comb begin
      w_state_d = r_state;
      w_idx_d   = r_idx;
      w_cnt_d   = r_idle_cnt;
      w_done_d  = 1'b0;
      w_error_d = r_error;
      w_key_we  = 1'b0;
      if (clear) begin
         w_state_d = StIdle;
         w_idx_d   = '0;
         w_cnt_d   = '0;
         w_error_d = 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  w_key_we  = 1'b1;
                  w_idx_d   = r_idx + 1'b1;
                  w_cnt_d   = '0;
                  w_state_d = (NUM_KEYS == 1) ? StLocked : StLoad;
                  w_done_d  = (NUM_KEYS == 1);
               end
            end
            StLoad: begin
               if (w_accept) begin
                  w_key_we = 1'b1;
                  w_idx_d  = r_idx + 1'b1;
                  w_cnt_d  = '0;
                  if (r_idx == LAST_IDX) begin
                     w_state_d = StLocked;
                     w_done_d  = 1'b1;
                  end
               end else if (in_valid) begin
                  // Non-key traffic in the middle of a load aborts it.
                  w_state_d = StErr;
                  w_error_d = 1'b1;
               end else begin
                  w_cnt_d = r_idle_cnt + 1'b1;
                  if (r_idle_cnt == CNT_LAST) begin
                     w_state_d = StErr;
                     w_error_d = 1'b1;
                  end
               end
            end
            StLocked: begin
               // Overwrite attempt: flag it, keep the set.
               if (in_valid && key_config) begin
                  w_error_d = 1'b1;
               end
            end
            StErr: begin
               w_error_d = 1'b1;
            end
         endcase
      end
   end

   // State registers and key bank; rst has priority over clear and beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StIdle;
         r_bank     <= '0;
         r_idx      <= '0;
         r_idle_cnt <= '0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_idx      <= w_idx_d;
         r_idle_cnt <= w_cnt_d;
         r_done     <= w_done_d;
         r_error    <= w_error_d;
         if (clear) begin
            r_bank <= '0;
         end else if (w_key_we) begin
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
               if (r_idx == IDX_W'(k)) begin
                  r_bank[k*KEY_W +: KEY_W] <= data_in;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_key_bank_loader.sv
// Bench for key_bank_loader: four instances (default, short timeout, 32x1, 128x8) share one
// stimulus stream and are checked every cycle against a queue-based reference model, plus
// a hand-derived vector table and directed multi-cycle sequences.
module tb_key_bank_loader;

   logic         clk = 1'b0;
   logic         rst, clear, in_valid, key_config;
   logic [127:0] data;

   logic [191:0]  ko0, ko1;
   logic [31:0]   ko2;
   logic [1023:0] ko3;
   logic [1:0]    ix0, ix1;
   logic [0:0]    ix2;
   logic [3:0]    ix3;
   logic          rdy_w[4], kv_w[4], done_w[4], err_w[4];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   key_bank_loader #(.KEY_W(64), .NUM_KEYS(3), .TIMEOUT(255)) u0 (
      .clk(clk), .rst(rst), .data_in(data[63:0]), .key_config(key_config),
      .in_valid(in_valid), .clear(clear), .rdy(rdy_w[0]), .key_out(ko0),
      .keys_valid(kv_w[0]), .key_idx(ix0), .done(done_w[0]), .error(err_w[0]));
   key_bank_loader #(.KEY_W(64), .NUM_KEYS(3), .TIMEOUT(4)) u1 (
      .clk(clk), .rst(rst), .data_in(data[63:0]), .key_config(key_config),
      .in_valid(in_valid), .clear(clear), .rdy(rdy_w[1]), .key_out(ko1),
      .keys_valid(kv_w[1]), .key_idx(ix1), .done(done_w[1]), .error(err_w[1]));
   key_bank_loader #(.KEY_W(32), .NUM_KEYS(1), .TIMEOUT(255)) u2 (
      .clk(clk), .rst(rst), .data_in(data[31:0]), .key_config(key_config),
      .in_valid(in_valid), .clear(clear), .rdy(rdy_w[2]), .key_out(ko2),
      .keys_valid(kv_w[2]), .key_idx(ix2), .done(done_w[2]), .error(err_w[2]));
   key_bank_loader #(.KEY_W(128), .NUM_KEYS(8), .TIMEOUT(255)) u3 (
      .clk(clk), .rst(rst), .data_in(data), .key_config(key_config),
      .in_valid(in_valid), .clear(clear), .rdy(rdy_w[3]), .key_out(ko3),
      .keys_valid(kv_w[3]), .key_idx(ix3), .done(done_w[3]), .error(err_w[3]));

   // ---------------- reference model ----------------
   typedef enum int {MIdle, MLoad, MLocked, MErr} mmode_t;
   logic [127:0] m_q[4][$];
   mmode_t       m_mode[4];
   int           m_idle[4];
   bit           m_done[4], m_err[4];

   function automatic int kw(input int i);
      case (i)
         0, 1:    return 64;
         2:       return 32;
         default: return 128;
      endcase
   endfunction

   function automatic int nk(input int i);
      case (i)
         0, 1:    return 3;
         2:       return 1;
         default: return 8;
      endcase
   endfunction

   function automatic int tmo(input int i);
      return (i == 1) ? 4 : 255;
   endfunction

   function automatic logic [127:0] kmask(input int i);
      if (kw(i) == 128) return '1;
      return (128'd1 << kw(i)) - 128'd1;
   endfunction

   task automatic model_step(input logic r, c, v, k, input logic [127:0] d);
      for (int i = 0; i < 4; i++) begin
         if (r || c) begin
            m_q[i].delete();
            m_mode[i] = MIdle;
            m_idle[i] = 0;
            m_done[i] = 0;
            m_err[i]  = 0;
         end else begin
            m_done[i] = 0;
            case (m_mode[i])
               MIdle, MLoad: begin
                  if (v && k) begin
                     m_q[i].push_back(d & kmask(i));
                     m_idle[i] = 0;
                     if (m_q[i].size() == nk(i)) begin
                        m_mode[i] = MLocked;
                        m_done[i] = 1;
                     end else begin
                        m_mode[i] = MLoad;
                     end
                  end else if (m_mode[i] == MLoad) begin
                     if (v) begin
                        m_mode[i] = MErr;
                        m_err[i]  = 1;
                     end else begin
                        m_idle[i]++;
                        if (m_idle[i] >= tmo(i)) begin
                           m_mode[i] = MErr;
                           m_err[i]  = 1;
                        end
                     end
                  end
               end
               MLocked: if (v && k) m_err[i] = 1;
               default: ;
            endcase
         end
      end
   endtask

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_inst(input int i);
      logic [1023:0] ak, sh;
      int            ai;
      logic [127:0]  ek;
      ak = '0;
      case (i)
         0:       begin ak[191:0] = ko0; ai = int'(ix0); end
         1:       begin ak[191:0] = ko1; ai = int'(ix1); end
         2:       begin ak[31:0]  = ko2; ai = int'(ix2); end
         default: begin ak        = ko3; ai = int'(ix3); end
      endcase
      chk($sformatf("u%0d rdy", i), 128'(rdy_w[i]),
          128'((m_mode[i] == MIdle) || (m_mode[i] == MLoad)));
      chk($sformatf("u%0d keys_valid", i), 128'(kv_w[i]), 128'(m_mode[i] == MLocked));
      chk($sformatf("u%0d done", i), 128'(done_w[i]), 128'(m_done[i]));
      chk($sformatf("u%0d error", i), 128'(err_w[i]), 128'(m_err[i]));
      chk($sformatf("u%0d key_idx", i), 128'(ai), 128'(m_q[i].size()));
      for (int k = 0; k < nk(i); k++) begin
         sh = ak >> (k * kw(i));
         ek = (k < m_q[i].size()) ? m_q[i][k] : 128'd0;
         chk($sformatf("u%0d key%0d", i, k), sh[127:0] & kmask(i), ek);
      end
   endtask

   // Drive inputs, clock once, advance the model, then sample 1 time unit after the edge.
   task automatic cycle(input logic r, c, v, k, input logic [127:0] d);
      rst = r; clear = c; in_valid = v; key_config = k; data = d;
      @(posedge clk);
      model_step(r, c, v, k, d);
      #1;
      for (int i = 0; i < 4; i++) check_inst(i);
   endtask

   task automatic beat(input logic [127:0] d);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, d);
   endtask

   task automatic idle_cyc();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 128'd0);
   endtask

   // ---------------- vector table (expectations for u0) ----------------
   typedef struct {
      logic r, c, v, k;
      logic [127:0] d;
      logic e_rdy, e_kv, e_done, e_err;
      int   e_idx;
   } vec_t;

   function automatic vec_t mk(input logic r, c, v, k, input logic [127:0] d,
                               input logic e_rdy, e_kv, e_done, e_err, input int e_idx);
      vec_t t;
      t.r = r; t.c = c; t.v = v; t.k = k; t.d = d;
      t.e_rdy = e_rdy; t.e_kv = e_kv; t.e_done = e_done; t.e_err = e_err; t.e_idx = e_idx;
      return t;
   endfunction

   vec_t tbl[17];

   initial begin
      logic [127:0] ff64;
      ff64 = {64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; key_config = 1'b0; data = '0;

      //             r  c  v  k  data      rdy kv dn er idx
      tbl[0]  = mk(1, 0, 0, 0, 128'h0,  1, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 128'h0,  1, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 1, 0, 128'h99, 1, 0, 0, 0, 0);  // idle ignores data traffic
      tbl[3]  = mk(0, 0, 1, 1, 128'hA1, 1, 0, 0, 0, 1);
      tbl[4]  = mk(0, 0, 1, 1, 128'hB2, 1, 0, 0, 0, 2);
      tbl[5]  = mk(0, 0, 1, 1, 128'hC3, 0, 1, 1, 0, 3);
      tbl[6]  = mk(0, 0, 0, 0, 128'h0,  0, 1, 0, 0, 3);
      tbl[7]  = mk(0, 0, 1, 0, 128'h55, 0, 1, 0, 0, 3);  // locked ignores data traffic
      tbl[8]  = mk(0, 0, 1, 1, ff64,    0, 1, 0, 1, 3);  // overwrite attempt
      tbl[9]  = mk(0, 1, 0, 0, 128'h0,  1, 0, 0, 0, 0);
      tbl[10] = mk(0, 0, 1, 1, 128'h11, 1, 0, 0, 0, 1);
      tbl[11] = mk(0, 1, 1, 1, 128'h22, 1, 0, 0, 0, 0);  // clear beats the beat
      tbl[12] = mk(0, 0, 1, 1, 128'h33, 1, 0, 0, 0, 1);
      tbl[13] = mk(0, 0, 1, 0, 128'h44, 0, 0, 0, 1, 1);  // interrupted load
      tbl[14] = mk(0, 0, 1, 1, 128'h45, 0, 0, 0, 1, 1);  // err holds
      tbl[15] = mk(0, 1, 0, 0, 128'h0,  1, 0, 0, 0, 0);
      tbl[16] = mk(1, 0, 1, 1, 128'h66, 1, 0, 0, 0, 0);  // rst beats the beat

      for (int n = 0; n < 17; n++) begin
         cycle(tbl[n].r, tbl[n].c, tbl[n].v, tbl[n].k, tbl[n].d);
         chk($sformatf("tbl%0d rdy", n), 128'(rdy_w[0]), 128'(tbl[n].e_rdy));
         chk($sformatf("tbl%0d keys_valid", n), 128'(kv_w[0]), 128'(tbl[n].e_kv));
         chk($sformatf("tbl%0d done", n), 128'(done_w[0]), 128'(tbl[n].e_done));
         chk($sformatf("tbl%0d error", n), 128'(err_w[0]), 128'(tbl[n].e_err));
         chk($sformatf("tbl%0d key_idx", n), 128'(ix0), 128'(tbl[n].e_idx));
      end

      // Full load then overwrite attempt.
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 128'd0);
      beat(128'hA1); beat(128'hB2); beat(128'hC3);
      chk("full done", 128'(done_w[0]), 128'd1);
      chk("full key_out", 128'(ko0), 128'({64'hC3, 64'hB2, 64'hA1}));
      chk("full rdy", 128'(rdy_w[0]), 128'd0);
      idle_cyc();
      chk("full done one cycle", 128'(done_w[0]), 128'd0);
      chk("full keys_valid", 128'(kv_w[0]), 128'd1);
      beat(ff64);
      chk("ovw error", 128'(err_w[0]), 128'd1);
      chk("ovw keys_valid", 128'(kv_w[0]), 128'd1);
      chk("ovw key_out", 128'(ko0), 128'({64'hC3, 64'hB2, 64'hA1}));

      // Interrupted load.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 128'd0);
      beat(128'h5A);
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 128'h77);
      chk("intr error", 128'(err_w[0]), 128'd1);
      chk("intr rdy", 128'(rdy_w[0]), 128'd0);
      chk("intr key_out", 128'(ko0), 128'h5A);

      // Clear collides with the second beat, then a clean reload.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 128'd0);
      beat(128'h11);
      cycle(1'b0, 1'b1, 1'b1, 1'b1, 128'h22);
      chk("clr key_out", 128'(ko0), 128'd0);
      chk("clr key_idx", 128'(ix0), 128'd0);
      beat(128'h1); beat(128'h2); beat(128'h3);
      chk("reload keys_valid", 128'(kv_w[0]), 128'd1);
      chk("reload key_out", 128'(ko0), 128'({64'h3, 64'h2, 64'h1}));

      // Gapped load: 10-cycle gaps lock u0, but u1 (TIMEOUT=4) errors on the 4th idle cycle.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 128'd0);
      beat(128'hD1);
      repeat (3) idle_cyc();
      chk("gap u1 err before timeout", 128'(err_w[1]), 128'd0);
      chk("gap u1 rdy before timeout", 128'(rdy_w[1]), 128'd1);
      idle_cyc();
      chk("gap u1 err at timeout", 128'(err_w[1]), 128'd1);
      chk("gap u1 rdy at timeout", 128'(rdy_w[1]), 128'd0);
      repeat (6) idle_cyc();
      beat(128'hD2);
      repeat (10) idle_cyc();
      beat(128'hD3);
      chk("gap u0 keys_valid", 128'(kv_w[0]), 128'd1);
      chk("gap u0 error", 128'(err_w[0]), 128'd0);
      chk("gap u0 key_out", 128'(ko0), 128'({64'hD3, 64'hD2, 64'hD1}));
      chk("gap u1 still err", 128'(err_w[1]), 128'd1);

      // Parameter sweep: reset after 5 beats.
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 128'd0);
      for (int b = 0; b < 5; b++) beat({$urandom, $urandom, $urandom, $urandom});
      chk("sweep u3 key_idx", 128'(ix3), 128'd5);
      chk("sweep u2 keys_valid", 128'(kv_w[2]), 128'd1);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 128'd0);
      chk("sweep u2 key_out", 128'(ko2), 128'd0);
      chk("sweep u3 key_out", 128'(ko3 != '0), 128'd0);
      chk("sweep u3 key_idx rst", 128'(ix3), 128'd0);
      chk("sweep u2 keys_valid rst", 128'(kv_w[2]), 128'd0);
      chk("sweep u2 error rst", 128'(err_w[2]), 128'd0);
      chk("sweep u3 rdy rst", 128'(rdy_w[3]), 128'd1);

      // Random: first only key beats (so long loads complete), then unconstrained traffic.
      for (int n = 0; n < 600; n++) begin
         cycle(($urandom_range(0, 127) == 0), ($urandom_range(0, 79) == 0),
               ($urandom_range(0, 2) == 0), 1'b1,
               {$urandom, $urandom, $urandom, $urandom});
      end
      for (int n = 0; n < 900; n++) begin
         cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
               ($urandom_range(0, 1) == 0), ($urandom_range(0, 7) != 0),
               {$urandom, $urandom, $urandom, $urandom});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/key_bank_loader.md
KEY_BANK_LOADER -- requirements
Module: key_bank_loader

Interface
REQ-001 Parameter KEY_W, default 64, width of each key word and of data_in.
REQ-002 Parameter NUM_KEYS, default 3, number of keys in a full set (legal range 1..16).
REQ-003 Parameter TIMEOUT, default 255, maximum idle cycles allowed between key words during a load.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high; the ports are named clk and rst.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 data_in  input  KEY_W  key word.
REQ-008 key_config  input  1  qualifies in_valid as a key-load beat.
REQ-009 in_valid  input  1  data_in valid this cycle.
REQ-010 clear  input  1  abandon or unlock the key set and return to IDLE.
REQ-011 rdy  output  1  block accepts a key-load beat this cycle.
REQ-012 key_out  output  NUM_KEYS*KEY_W  key k at bits [k*KEY_W +: KEY_W].
REQ-013 keys_valid  output  1  full key set loaded and locked.
REQ-014 key_idx  output  clog2(NUM_KEYS+1)  index of the next key to be written.
REQ-015 done  output  1  one-cycle pulse when the last key is captured.
REQ-016 error  output  1  sticky protocol-error flag.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, LOCKED and ERR.
REQ-018 A beat SHALL be accepted on a cycle where rdy, in_valid and key_config are all 1.
REQ-019 rdy SHALL be 1 in IDLE and LOAD and 0 in LOCKED and ERR.
REQ-020 Accepted beat: key[key_idx] <= data_in, key_idx increments, idle counter resets to 0; the key is visible on key_out in the next cycle.
REQ-021 IDLE: an accepted beat SHALL go to LOAD, or to LOCKED if NUM_KEYS==1.
REQ-022 LOAD: the beat writing key NUM_KEYS-1 SHALL go to LOCKED; done=1 and keys_valid=1 in the following cycle; done is 1 for exactly one cycle.
REQ-023 LOAD: in_valid=1 with key_config=0 SHALL go to ERR (interrupted load); data_in is not written.
REQ-024 LOAD: the idle counter SHALL increment on each cycle with no accepted beat; when it reaches TIMEOUT, go to ERR.
REQ-025 LOCKED: in_valid=1 with key_config=1 SHALL set error (overwrite attempt); the keys stay unchanged and the state stays LOCKED.
REQ-026 LOCKED: in_valid with key_config=0 is normal data traffic and SHALL be ignored.
REQ-027 ERR: error=1, keys_valid=0, and the state SHALL stay in ERR until clear or rst.
REQ-028 clear=1 in any state SHALL return to IDLE next cycle, zero all keys, key_idx and the idle counter, and deassert error, keys_valid and done.
REQ-029 If clear and an accepting beat occur in the same cycle, clear SHALL win; the beat is dropped.
REQ-030 IDLE SHALL ignore in_valid with key_config=0; IDLE SHALL not run the idle counter.
REQ-031 key_idx SHALL saturate at NUM_KEYS in LOCKED; it never wraps.

Reset
REQ-032 rst=1 at a rising edge SHALL, on the next cycle, force IDLE, key_out=0, key_idx=0, idle counter=0, keys_valid=0, done=0, error=0, rdy=1.
REQ-033 Reset mid-load SHALL discard the partial key set; rst SHALL have priority over clear and over beats.

Verification
REQ-034 Full load, defaults: beats A1,B2,C3 (64-bit) on consecutive cycles -> key_out={C3,B2,A1}; done pulses 1 cycle after the 3rd beat; keys_valid=1; rdy=0.
REQ-035 Gapped load: beats with 10-cycle gaps, TIMEOUT=255 -> the set locks normally; with TIMEOUT=4 -> ERR after the 4th idle cycle; error=1; rdy=0.
REQ-036 Interrupted load: 1 key beat, then in_valid=1 with key_config=0 -> ERR; key1 slot remains 0.
REQ-037 Overwrite attempt: after lock, beat FF..FF with key_config=1 -> error=1; keys unchanged; keys_valid stays 1.
REQ-038 clear together with the 2nd beat -> IDLE; all keys 0; key_idx=0; a subsequent 3-beat load succeeds.
REQ-039 Parameter sweep KEY_W=32, NUM_KEYS=1 and KEY_W=128, NUM_KEYS=8; rst asserted after 5 beats -> all outputs at reset values next cycle.
